// File: rtl/cam_write_arbiter.sv
// cam_write_arbiter
// Round-robin burst arbiter that shares one Avalon-MM bursting write port
// between the left (0) and right (1) camera line FIFOs. Each grant moves one
// BURST_LEN-word burst into that requester's frame buffer. The block walks a
// per-requester write offset through the frame buffer and pulses frame_done
// on the last beat of each frame.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no burst active; requests sampled, round-robin grant on a tie
// BURST | streaming BURST_LEN beats from the granted FIFO, address held

module cam_write_arbiter #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 24,
   parameter int BURST_LEN   = 8,
   parameter int FRAME_WORDS = 307200,
   parameter int BASE0       = 0,
   parameter int BASE1       = 307200
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          req0,
   input  logic                          req1,
   input  logic [DATA_WIDTH-1:0]         data0,
   input  logic [DATA_WIDTH-1:0]         data1,
   output logic                          pop0,
   output logic                          pop1,
   output logic [ADDR_WIDTH-1:0]         mem_address,
   output logic [$clog2(BURST_LEN):0]    mem_burstcount,
   output logic                          mem_write,
   output logic [DATA_WIDTH-1:0]         mem_writedata,
   input  logic                          mem_waitrequest,
   output logic                          frame_done0,
   output logic                          frame_done1,
   output logic                          busy
);

   localparam int BW  = $clog2(BURST_LEN);
   localparam int BCW = $clog2(BURST_LEN) + 1;

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_gnt;
   logic                  r_last_gnt;
   logic [ADDR_WIDTH-1:0] r_off0;
   logic [ADDR_WIDTH-1:0] r_off1;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [BW-1:0]         r_beat;

   logic                  w_any_req;
   logic                  w_pick;
   logic                  w_accept;
   logic                  w_last;
   logic [ADDR_WIDTH-1:0] w_off_cur;
   logic [ADDR_WIDTH-1:0] w_off_inc;
   logic                  w_wrap;

   assign w_any_req = req0 | req1;
   // On a tie the requester not granted last wins; otherwise whoever asks.
   assign w_pick    = (req0 & req1) ? ~r_last_gnt : req1;

   assign w_accept  = (r_state == BURST) & ~mem_waitrequest;
   // r_beat counts remaining beats down; zero means this is the final beat.
   assign w_last    = w_accept & (r_beat == '0);
   assign w_off_cur = r_gnt ? r_off1 : r_off0;
   assign w_off_inc = w_off_cur + ADDR_WIDTH'(BURST_LEN);
   assign w_wrap    = (w_off_inc == ADDR_WIDTH'(FRAME_WORDS));

   assign mem_burstcount = BCW'(BURST_LEN);
   assign mem_address    = r_addr;

   // Next-state and burst-phase outputs.
   always_comb begin
      w_state_next  = r_state;
      mem_write     = 1'b0;
      busy          = 1'b0;
      pop0          = 1'b0;
      pop1          = 1'b0;
      frame_done0   = 1'b0;
      frame_done1   = 1'b0;
      mem_writedata = r_gnt ? data1 : data0;
      case (r_state)
         IDLE: begin
            if (w_any_req) w_state_next = BURST;
         end
         BURST: begin
            mem_write   = 1'b1;
            busy        = 1'b1;
            pop0        = w_accept & ~r_gnt;
            pop1        = w_accept &  r_gnt;
            frame_done0 = w_last & w_wrap & ~r_gnt;
            frame_done1 = w_last & w_wrap &  r_gnt;
            if (w_last) w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State register, grant capture, beat counter and per-requester offsets.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_gnt      <= 1'b0;
         r_last_gnt <= 1'b1;
         r_off0     <= '0;
         r_off1     <= '0;
         r_addr     <= '0;
         r_beat     <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == IDLE && w_any_req) begin
            r_gnt      <= w_pick;
            r_last_gnt <= w_pick;
            r_addr     <= w_pick ? (ADDR_WIDTH'(BASE1) + r_off1)
                                 : (ADDR_WIDTH'(BASE0) + r_off0);
            r_beat     <= BW'(BURST_LEN - 1);
         end
         if (w_accept) r_beat <= r_beat - BW'(1);
         if (w_last) begin
            if (r_gnt) r_off1 <= w_wrap ? '0 : w_off_inc;
            else       r_off0 <= w_wrap ? '0 : w_off_inc;
         end
      end
   end

endmodule

// File: tb/tb_cam_write_arbiter.sv
// Directed bench for cam_write_arbiter. Two instances share the FIFO models:
// dut_a uses a 32-word frame, dut_b a 16-word frame for the wrap case.

module tb_cam_write_arbiter;

   localparam int BL = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0a, req1a, req0b, req1b;
   logic [15:0] data0, data1;
   logic        mem_waitrequest;

   logic        a_pop0, a_pop1, a_write, a_fd0, a_fd1, a_busy;
   logic [23:0] a_addr;
   logic [3:0]  a_bc;
   logic [15:0] a_wdata;
   logic        b_pop0, b_pop1, b_write, b_fd0, b_fd1, b_busy;
   logic [23:0] b_addr;
   logic [3:0]  b_bc;
   logic [15:0] b_wdata;

   logic        sel;
   logic        o_pop0, o_pop1, o_write, o_fd0, o_fd1, o_busy;
   logic [23:0] o_addr;
   logic [15:0] o_wdata;

   int cnt0 = 0, cnt1 = 0;
   int exp_w0 = 0, exp_w1 = 0;
   int n_assert = 0, n_fail = 0;

   always #5 clk = ~clk;

   cam_write_arbiter #(.BURST_LEN(BL), .FRAME_WORDS(32), .BASE0(24'h100), .BASE1(24'h200)) dut_a (
      .clk(clk), .reset(reset), .req0(req0a), .req1(req1a), .data0(data0), .data1(data1),
      .pop0(a_pop0), .pop1(a_pop1), .mem_address(a_addr), .mem_burstcount(a_bc),
      .mem_write(a_write), .mem_writedata(a_wdata), .mem_waitrequest(mem_waitrequest),
      .frame_done0(a_fd0), .frame_done1(a_fd1), .busy(a_busy));

   cam_write_arbiter #(.BURST_LEN(BL), .FRAME_WORDS(16), .BASE0(24'h100), .BASE1(24'h200)) dut_b (
      .clk(clk), .reset(reset), .req0(req0b), .req1(req1b), .data0(data0), .data1(data1),
      .pop0(b_pop0), .pop1(b_pop1), .mem_address(b_addr), .mem_burstcount(b_bc),
      .mem_write(b_write), .mem_writedata(b_wdata), .mem_waitrequest(mem_waitrequest),
      .frame_done0(b_fd0), .frame_done1(b_fd1), .busy(b_busy));

   assign o_pop0  = sel ? b_pop0  : a_pop0;
   assign o_pop1  = sel ? b_pop1  : a_pop1;
   assign o_write = sel ? b_write : a_write;
   assign o_fd0   = sel ? b_fd0   : a_fd0;
   assign o_fd1   = sel ? b_fd1   : a_fd1;
   assign o_busy  = sel ? b_busy  : a_busy;
   assign o_addr  = sel ? b_addr  : a_addr;
   assign o_wdata = sel ? b_wdata : a_wdata;

   // Show-ahead FIFO models: head word advances on every pop.
   assign data0 = 16'hA000 + cnt0[15:0];
   assign data1 = 16'hB000 + cnt1[15:0];
   always @(posedge clk) begin
      if (a_pop0 | b_pop0) cnt0 <= cnt0 + 1;
      if (a_pop1 | b_pop1) cnt1 <= cnt1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      mem_waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Called at the negedge of the first burst cycle. Checks every beat, then
   // (for a full burst) the mandatory IDLE gap cycle and the burst length.
   task automatic run_burst(input logic g, input logic [23:0] addr, input logic [7:0] stall_at,
                            input logic fd_last, input int nbeats, input int exp_cyc,
                            input logic drop);
      int b = 0;
      int cyc = 0;
      logic [7:0] stall_done = 8'h00;
      logic w, last;
      logic [15:0] exp_data;
      while (b < nbeats && cyc < 40) begin
         w = stall_at[b] && !stall_done[b];
         mem_waitrequest = w;
         #1;
         exp_data = g ? (16'hB000 + exp_w1[15:0]) : (16'hA000 + exp_w0[15:0]);
         last = !w && (b == BL - 1);
         chk("burst_write", {31'b0, o_write}, 32'd1);
         chk("burst_busy", {31'b0, o_busy}, 32'd1);
         chk("burst_addr", {8'b0, o_addr}, {8'b0, addr});
         chk("pop_granted", {31'b0, (g ? o_pop1 : o_pop0)}, {31'b0, !w});
         chk("pop_other", {31'b0, (g ? o_pop0 : o_pop1)}, 32'd0);
         chk("writedata", {16'b0, o_wdata}, {16'b0, exp_data});
         chk("frame_done_gnt", {31'b0, (g ? o_fd1 : o_fd0)}, {31'b0, last && fd_last});
         chk("frame_done_other", {31'b0, (g ? o_fd0 : o_fd1)}, 32'd0);
         @(posedge clk);
         if (w) stall_done[b] = 1'b1;
         else begin
            b++;
            if (g) exp_w1++; else exp_w0++;
         end
         cyc++;
         @(negedge clk);
         if (drop && b >= 1) begin
            req0a = 1'b0; req1a = 1'b0; req0b = 1'b0; req1b = 1'b0;
         end
      end
      chk("burst_budget", {31'b0, (b == nbeats)}, 32'd1);
      if (nbeats == BL) begin
         mem_waitrequest = 1'b0;
         #1;
         chk("burst_cycles", cyc, exp_cyc);
         chk("gap_write", {31'b0, o_write}, 32'd0);
         chk("gap_busy", {31'b0, o_busy}, 32'd0);
         chk("gap_pops", {30'b0, o_pop1, o_pop0}, 32'd0);
      end
   endtask

   initial begin
      sel = 1'b0;
      req0a = 1'b0; req1a = 1'b0; req0b = 1'b0; req1b = 1'b0;
      mem_waitrequest = 1'b0;

      // Reset values
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_write", {31'b0, a_write}, 32'd0);
      chk("rst_busy", {31'b0, a_busy}, 32'd0);
      chk("rst_pops", {30'b0, a_pop1, a_pop0}, 32'd0);
      chk("rst_fd", {30'b0, a_fd1, a_fd0}, 32'd0);
      chk("rst_addr", {8'b0, a_addr}, 32'd0);
      chk("burstcount", {28'b0, a_bc}, 32'd8);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_no_req", {31'b0, a_write}, 32'd0);

      // Single requester
      do_reset();
      req0a = 1'b1;
      @(negedge clk);
      run_burst(1'b0, 24'h100, 8'h00, 1'b0, BL, BL, 1'b0);
      @(negedge clk);
      run_burst(1'b0, 24'h108, 8'h00, 1'b0, BL, BL, 1'b0);
      @(negedge clk);
      run_burst(1'b0, 24'h110, 8'h00, 1'b0, BL, BL, 1'b0);
      req0a = 1'b0;

      // Fair arbitration, requests high from reset
      reset = 1'b1;
      req0a = 1'b1; req1a = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_burst(1'b0, 24'h100, 8'h00, 1'b0, BL, BL, 1'b0);
      @(negedge clk);
      run_burst(1'b1, 24'h200, 8'h00, 1'b0, BL, BL, 1'b0);
      @(negedge clk);
      run_burst(1'b0, 24'h108, 8'h00, 1'b0, BL, BL, 1'b0);
      @(negedge clk);
      run_burst(1'b1, 24'h208, 8'h00, 1'b0, BL, BL, 1'b0);
      req0a = 1'b0; req1a = 1'b0;

      // Backpressure on beats 1 and 5
      do_reset();
      req0a = 1'b1;
      @(negedge clk);
      run_burst(1'b0, 24'h100, 8'b0010_0010, 1'b0, BL, 10, 1'b0);
      req0a = 1'b0;

      // Frame wrap on the 16-word instance
      sel = 1'b1;
      do_reset();
      req0b = 1'b1;
      @(negedge clk);
      run_burst(1'b0, 24'h100, 8'h00, 1'b0, BL, BL, 1'b0);
      @(negedge clk);
      run_burst(1'b0, 24'h108, 8'h00, 1'b1, BL, BL, 1'b0);
      @(negedge clk);
      run_burst(1'b0, 24'h100, 8'h00, 1'b0, BL, BL, 1'b0);
      req0b = 1'b0;
      sel = 1'b0;

      // Late request: req0 drops after the first beat
      do_reset();
      req0a = 1'b1;
      @(negedge clk);
      run_burst(1'b0, 24'h100, 8'h00, 1'b0, BL, BL, 1'b1);
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("late_stays_idle", {31'b0, a_write}, 32'd0);
      end

      // Reset mid-burst after 3 accepted beats
      do_reset();
      req0a = 1'b1;
      @(negedge clk);
      run_burst(1'b0, 24'h100, 8'h00, 1'b0, 3, 3, 1'b0);
      mem_waitrequest = 1'b1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("midrst_write", {31'b0, a_write}, 32'd0);
      chk("midrst_pops", {30'b0, a_pop1, a_pop0}, 32'd0);
      chk("midrst_fd", {30'b0, a_fd1, a_fd0}, 32'd0);
      chk("midrst_busy", {31'b0, a_busy}, 32'd0);
      @(negedge clk);
      mem_waitrequest = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      run_burst(1'b0, 24'h100, 8'h00, 1'b0, BL, BL, 1'b0);
      req0a = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
